// File: rtl/kamus_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// kamus_fetch_ctrl
//   Instruction-fetch sequencer for the kamus-v IF stage. Owns the PC, runs the
//   req/gnt/rvalid handshake to instruction memory with at most one request
//   outstanding, applies branch/jump redirects, drops stale responses and
//   holds the fetched instruction/PC pair until ID accepts it.
//
// Optional feature (compile-time macro KAMUS_FETCH_PERF_EN):
//   adds perf_stall_cnt_o, a saturating count of cycles with no valid
//   instruction presented to ID and no redirect asserted.
//
// Parameters
//   BOOT_ADDR         PC loaded on reset (word aligned)
//
// Ports
//   clk_i             clock, all state on the rising edge
//   rst_i             synchronous reset, active high
//   redirect_valid_i  branch/jump taken this cycle
//   redirect_addr_i   redirect target (low two bits force-aligned)
//   stall_i           ID not ready; output pair is held
//   imem_req_o        fetch request
//   imem_addr_o       fetch address (word aligned)
//   imem_gnt_i        request accepted
//   imem_rvalid_i     response valid (one per granted request)
//   imem_rdata_i      instruction word
//   if_valid_o        if_instr_o / if_pc_o valid
//   if_instr_o        fetched instruction
//   if_pc_o           PC of if_instr_o
//   if_misalign_o     one-cycle pulse: accepted redirect was not word aligned
//   perf_stall_cnt_o  (KAMUS_FETCH_PERF_EN only) fetch-bubble counter
// -----------------------------------------------------------------------------
module kamus_fetch_ctrl #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_addr_i,
    input  logic        stall_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o,
    output logic        if_misalign_o
`ifdef KAMUS_FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic        r_kill;
    logic        r_pend_vld;
    logic [31:0] r_pend_addr;
    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic [31:0] r_skid_instr;
    logic        r_misalign;

    logic [31:0] w_redir_tgt;
    logic        w_out_free;
    logic        w_rsp;
    logic        w_rsp_live;
    logic        w_capture;
    logic        w_park;
    logic        w_unpark;
    logic        w_load_out;
    logic [31:0] w_load_data;
    logic [31:0] w_pc_inc;

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    assign w_redir_tgt = {redirect_addr_i[31:2], 2'b00};
    assign w_pc_inc    = r_pc + 32'd4;

    // Output register can take new data if empty or being consumed this cycle.
    assign w_out_free  = !r_out_valid || !stall_i;

    // A response only counts in WAIT; anywhere else it is a stray and ignored.
    assign w_rsp       = (r_state == S_WAIT) && imem_rvalid_i;
    assign w_rsp_live  = w_rsp && !r_kill && !redirect_valid_i;
    assign w_capture   = w_rsp_live && w_out_free;
    assign w_park      = w_rsp_live && !w_out_free;
    assign w_unpark    = (r_state == S_HOLD) && !redirect_valid_i && w_out_free;
    assign w_load_out  = w_capture || w_unpark;
    assign w_load_data = w_capture ? imem_rdata_i : r_skid_instr;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (imem_gnt_i) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Redirect without a response keeps us waiting for the
                // (now killed) outstanding response.
                if (imem_rvalid_i) begin
                    if (w_park) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid_i || w_out_free) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = r_pc;
        if (r_state == S_REQ) begin
            imem_req_o = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // PC, kill and pending-redirect tracking
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc        <= BOOT_ADDR;
            r_kill      <= 1'b0;
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
        end else begin
            // PC
            if (redirect_valid_i) begin
                // In REQ without gnt the address on the bus must stay put,
                // so the target waits in the pending register instead.
                if (!((r_state == S_REQ) && !imem_gnt_i)) begin
                    r_pc <= w_redir_tgt;
                end
            end else if ((r_state == S_REQ) && imem_gnt_i && r_pend_vld) begin
                // The granted request is already doomed by kill; the PC can
                // take the pending target now since nothing reads it in WAIT.
                r_pc <= r_pend_addr;
            end else if (w_load_out) begin
                r_pc <= w_pc_inc;
            end

            // Pending target
            if ((r_state == S_REQ) && imem_gnt_i) begin
                r_pend_vld <= 1'b0;
            end else if ((r_state == S_REQ) && redirect_valid_i) begin
                r_pend_vld  <= 1'b1;
                r_pend_addr <= w_redir_tgt;
            end

            // Kill flag: marks the single outstanding response as stale.
            if (redirect_valid_i) begin
                case (r_state)
                    S_REQ:   r_kill <= 1'b1;
                    S_WAIT:  r_kill <= !imem_rvalid_i;
                    default: r_kill <= 1'b0;
                endcase
            end else if (w_rsp) begin
                r_kill <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register, skid register, misalign pulse
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid  <= 1'b0;
            r_out_instr  <= '0;
            r_out_pc     <= '0;
            r_skid_instr <= '0;
            r_misalign   <= 1'b0;
        end else begin
            r_misalign <= redirect_valid_i && (|redirect_addr_i[1:0]);

            if (redirect_valid_i) begin
                r_out_valid <= 1'b0;
            end else if (w_load_out) begin
                // While parked in HOLD the PC has not advanced yet, so r_pc
                // is still the PC of the skid word.
                r_out_valid <= 1'b1;
                r_out_instr <= w_load_data;
                r_out_pc    <= r_pc;
            end else if (!stall_i) begin
                r_out_valid <= 1'b0;
            end

            if (w_park) begin
                r_skid_instr <= imem_rdata_i;
            end
        end
    end

    assign if_valid_o    = r_out_valid;
    assign if_instr_o    = r_out_instr;
    assign if_pc_o       = r_out_pc;
    assign if_misalign_o = r_misalign;

`ifdef KAMUS_FETCH_PERF_EN
    // -------------------------------------------------------------------------
    // Fetch-bubble counter (saturating)
    // -------------------------------------------------------------------------
    logic [31:0] r_perf_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_cnt <= '0;
        end else if (!r_out_valid && !redirect_valid_i && (r_perf_cnt != '1)) begin
            r_perf_cnt <= r_perf_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt_o = r_perf_cnt;
`endif

endmodule

// File: tb/tb_kamus_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for kamus_fetch_ctrl. A behavioural memory answers granted requests
// after a random latency; the expected instruction stream is the program-order
// PC sequence (start at BOOT, +4 per delivered word, restart at the aligned
// target on redirect, back to BOOT on reset) with data as a fixed function of
// the address.
// -----------------------------------------------------------------------------
module tb_kamus_fetch_ctrl;

    localparam logic [31:0] BOOT   = 32'h0000_0000;
    localparam int unsigned NCYC   = 4000;

    logic        clk;
    logic        rst;
    logic        redir;
    logic [31:0] redir_addr;
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ifv;
    logic [31:0] ifinstr;
    logic [31:0] ifpc;
    logic        mis;
`ifdef KAMUS_FETCH_PERF_EN
    logic [31:0] perf;
`endif

    kamus_fetch_ctrl #(
        .BOOT_ADDR(BOOT)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .redirect_valid_i (redir),
        .redirect_addr_i  (redir_addr),
        .stall_i          (stall),
        .imem_req_o       (req),
        .imem_addr_o      (addr),
        .imem_gnt_i       (gnt),
        .imem_rvalid_i    (rvalid),
        .imem_rdata_i     (rdata),
        .if_valid_o       (ifv),
        .if_instr_o       (ifinstr),
        .if_pc_o          (ifpc),
        .if_misalign_o    (mis)
`ifdef KAMUS_FETCH_PERF_EN
        ,
        .perf_stall_cnt_o (perf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(0, 5))
            0:       t = 32'h0000_0100;
            1:       t = 32'h0000_0102;
            2:       t = 32'hFFFF_FFF4;
            3:       t = 32'hFFFF_FFFB;
            default: t = $urandom;
        endcase
        return t;
    endfunction

    // Reference model / memory state
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    int unsigned n_cons;
    int unsigned n_rst;
    logic        mem_busy, mem_stale;
    logic [31:0] mem_addr;
    int unsigned mem_lat;
    logic        prev_rst, prev_redir, prev_mis, prev_hold, prev_req_wait;
    logic [31:0] prev_instr, prev_pc, prev_addr;

    initial begin
        int unsigned gnt_pct, max_lat, stall_pct, redir_pct;
        logic [31:0] tgt;

        rst = 1'b1; redir = 1'b0; redir_addr = '0; stall = 1'b0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        exp_pc = BOOT; exp_cnt = '0; n_cons = 0; n_rst = 0;
        mem_busy = 1'b0; mem_stale = 1'b0; mem_addr = '0; mem_lat = 0;
        prev_rst = 1'b0; prev_redir = 1'b0; prev_mis = 1'b0; prev_hold = 1'b0;
        prev_req_wait = 1'b0; prev_instr = '0; prev_pc = '0; prev_addr = '0;

        for (int unsigned c = 0; c < NCYC; c++) begin
            @(negedge clk);

            // ---------------- checks on state after the last rising edge
            if (c > 0) begin
                if (prev_rst) begin
                    chk("rst_req",   32'(req),  32'd0);
                    chk("rst_addr",  addr,      BOOT);
                    chk("rst_valid", 32'(ifv),  32'd0);
                    chk("rst_mis",   32'(mis),  32'd0);
                end else begin
                    chk("misalign", 32'(mis), 32'(prev_mis));
                    if (prev_redir) chk("redir_squash", 32'(ifv), 32'd0);
                    if (prev_hold) begin
                        chk("hold_valid", 32'(ifv), 32'd1);
                        chk("hold_instr", ifinstr, prev_instr);
                        chk("hold_pc",    ifpc,    prev_pc);
                    end
                    if (prev_req_wait) begin
                        chk("req_held",  32'(req), 32'd1);
                        chk("addr_held", addr,     prev_addr);
                    end
                end
                if (req) begin
                    chk("addr_align", 32'(addr[1:0]), 32'd0);
                    chk("single_outstanding", 32'(mem_busy && !mem_stale), 32'd0);
                end
`ifdef KAMUS_FETCH_PERF_EN
                chk("perf_cnt", perf, exp_cnt);
`endif
            end

            // ---------------- stimulus knobs
            if (c < 80) begin
                gnt_pct = 100; max_lat = 0; stall_pct = 0;  redir_pct = 0;
            end else if (c < 300) begin
                gnt_pct = 100; max_lat = 0; stall_pct = 60; redir_pct = 0;
            end else begin
                gnt_pct = 55;  max_lat = 4; stall_pct = 30; redir_pct = 7;
            end

            rst = (c < 2) || ((c >= 300) && mem_busy && !mem_stale &&
                              ($urandom_range(0, 119) == 0));
            if (rst) n_rst++;

            redir = 1'b0;
            tgt   = $urandom;
            if (!rst && ($urandom_range(0, 99) < redir_pct)) begin
                redir = 1'b1;
                tgt   = pick_target();
            end
            redir_addr = tgt;
            stall = ($urandom_range(0, 99) < stall_pct);

            // ---------------- behavioural memory
            rvalid = 1'b0;
            rdata  = $urandom;
            if (mem_busy) begin
                if (mem_lat == 0) begin
                    rvalid    = 1'b1;
                    // Stale (pre-reset) responses carry a poisoned word.
                    rdata     = mem_stale ? ~mem_word(mem_addr) : mem_word(mem_addr);
                    mem_busy  = 1'b0;
                    mem_stale = 1'b0;
                end else begin
                    mem_lat--;
                end
            end
            if (rst && mem_busy) mem_stale = 1'b1;

            gnt = 1'b0;
            if (req && !mem_busy && !rst && ($urandom_range(0, 99) < gnt_pct)) begin
                gnt      = 1'b1;
                mem_busy = 1'b1;
                mem_addr = addr;
                mem_lat  = $urandom_range(0, max_lat);
            end

            // ---------------- reference stream
            if (rst) begin
                exp_pc = BOOT;
            end else begin
                if (ifv && !stall && !redir) begin
                    chk("stream_pc",    ifpc,    exp_pc);
                    chk("stream_instr", ifinstr, mem_word(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    n_cons++;
                end
                if (redir) exp_pc = {tgt[31:2], 2'b00};
            end

            if (rst) exp_cnt = '0;
            else if (!ifv && !redir && (exp_cnt != 32'hFFFF_FFFF)) exp_cnt = exp_cnt + 32'd1;

            prev_rst      = rst;
            prev_redir    = redir;
            prev_mis      = redir && (tgt[1:0] != 2'b00);
            prev_hold     = ifv && stall && !redir && !rst;
            prev_instr    = ifinstr;
            prev_pc       = ifpc;
            prev_req_wait = req && !gnt && !rst;
            prev_addr     = addr;
        end

        // Forward progress over the whole run.
        chk("progress", 32'(n_cons >= 300), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
